// File: rtl/my_uart_rx_ctrl.sv
// my_uart_rx_ctrl: self-timed RS232 receiver (start + 8 data LSB first + optional parity + 1 stop)
// with a valid strobe, a busy flag and per-frame error flags for the host register block.
module my_uart_rx_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    input  logic       r_rx_en,
    input  logic [1:0] r_pari_mode,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int BPS_CNT = CLK_FREQ / BAUD;
    localparam int CW = $clog2(BPS_CNT);
    localparam logic [CW-1:0] LAST    = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BPS_CNT / 2 - 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic          s1_q, s2_q, dly_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [1:0]    pm_q, pm_d;
    logic          pbit_q, pbit_d;
    logic          stop_q, stop_d;
    logic          fin_q, fin_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_int_q, rx_int_d;
    logic          rx_valid_q, rx_valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          fall, tick, par_en;

    assign fall   = dly_q & ~s2_q;
    assign tick   = cnt_q == LAST;
    assign par_en = (pm_q == 2'b01) || (pm_q == 2'b10);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        pm_d       = pm_q;
        pbit_d     = pbit_q;
        stop_d     = stop_q;
        fin_d      = 1'b0;
        rx_data_d  = rx_data_q;
        rx_int_d   = rx_int_q;
        rx_valid_d = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        // fin_q marks the clock after the mid-stop sample: publish the frame and drop busy together
        if (fin_q) begin
            rx_data_d  = shreg_q;
            ferr_d     = ~stop_q;
            perr_d     = pm_q == 2'b01 ? pbit_q != ~^shreg_q :
                         pm_q == 2'b10 ? pbit_q != ^shreg_q : 1'b0;
            rx_valid_d = 1'b1;
            rx_int_d   = 1'b0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: if (fall && r_rx_en) begin
                    state_d = START;
                    pm_d    = r_pari_mode;
                end
                START: if (cnt_q == HALF_M1) begin
                    state_d  = s2_q ? IDLE : DATA;
                    rx_int_d = s2_q ? rx_int_q : 1'b1;
                    idx_d    = 3'd0;
                end
                DATA: if (tick) begin
                    shreg_d = {s2_q, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = par_en ? PARITY : STOP;
                end
                PARITY: if (tick) begin
                    pbit_d  = s2_q;
                    state_d = STOP;
                end
                STOP: if (tick) begin
                    stop_d = s2_q;
                    fin_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        cnt_d = (state_d != state_q || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            dly_q      <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shreg_q    <= 8'd0;
            pm_q       <= 2'b00;
            pbit_q     <= 1'b0;
            stop_q     <= 1'b0;
            fin_q      <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_int_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            s1_q       <= rs232_rx;
            s2_q       <= s1_q;
            dly_q      <= s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            pm_q       <= pm_d;
            pbit_q     <= pbit_d;
            stop_q     <= stop_d;
            fin_q      <= fin_d;
            rx_data_q  <= rx_data_d;
            rx_int_q   <= rx_int_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_int     = rx_int_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
endmodule
